// File: rtl/pll_lock_reset_sequencer.sv
// PLL lock qualifier and ordered per-domain reset release sequencer.
// Optional lock-loss counter enabled by defining PLL_LOCK_LOSS_COUNTER_EN.
module pll_lock_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
    parameter int unsigned RELEASE_STEP_CYCLES = 16,
    parameter int unsigned NUM_RESETS          = 3,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned PLL_RST_CYCLES      = 10,
    parameter int unsigned CNT_W               = 20
`ifdef PLL_LOCK_LOSS_COUNTER_EN
    ,
    parameter int unsigned LOSS_CNT_W          = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock_in,
    output logic                  pll_rst_out,
    output logic [NUM_RESETS-1:0] domain_rst_out,
    output logic                  all_released,
    output logic [2:0]            state_out
`ifdef PLL_LOCK_LOSS_COUNTER_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_STABILIZE = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_LOST      = 3'd4,
        S_PLL_RST   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] STAB_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(RELEASE_STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    w_lock_s;
    logic [NUM_RESETS-1:0]   r_domain_rst;
    logic [NUM_RESETS-1:0]   w_domain_rst_nxt;
    logic [NUM_RESETS-1:0]   w_dom_shift;
    logic                    r_pll_rst;
    logic                    w_pll_rst_nxt;
    logic                    r_all_released;
    logic                    w_all_released_nxt;

    assign w_lock_s = r_sync2;

    // Two-flop synchroniser for the asynchronous lock flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_WAIT_LOCK;
            r_cnt          <= '0;
            r_domain_rst   <= '1;
            r_pll_rst      <= 1'b0;
            r_all_released <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_domain_rst   <= w_domain_rst_nxt;
            r_pll_rst      <= w_pll_rst_nxt;
            r_all_released <= w_all_released_nxt;
        end
    end

    // Next state plus next values of the registered outputs; releases shift out from bit 0 upward
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_domain_rst_nxt   = r_domain_rst;
        w_pll_rst_nxt      = 1'b0;
        w_all_released_nxt = 1'b0;
        w_dom_shift        = r_domain_rst << 1;

        case (r_state)
            S_WAIT_LOCK: begin
                w_domain_rst_nxt = '1;
                if (w_lock_s) begin
                    w_state_nxt = S_STABILIZE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt   = S_PLL_RST;
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STABILIZE: begin
                w_domain_rst_nxt = '1;
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STAB_LAST) begin
                    w_state_nxt      = S_RELEASE;
                    w_cnt_nxt        = '0;
                    w_domain_rst_nxt = w_dom_shift;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!w_lock_s) begin
                    w_state_nxt      = S_LOST;
                    w_cnt_nxt        = '0;
                    w_domain_rst_nxt = '1;
                end else if (r_domain_rst == '0) begin
                    // Single-domain build: bit 0 already cleared on entry
                    w_state_nxt        = S_RUN;
                    w_cnt_nxt          = '0;
                    w_all_released_nxt = 1'b1;
                end else if (r_cnt == STEP_LAST) begin
                    w_cnt_nxt        = '0;
                    w_domain_rst_nxt = w_dom_shift;
                    if (w_dom_shift == '0) begin
                        w_state_nxt        = S_RUN;
                        w_all_released_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt      = S_LOST;
                    w_cnt_nxt        = '0;
                    w_domain_rst_nxt = '1;
                end else begin
                    w_all_released_nxt = 1'b1;
                end
            end
            S_LOST: begin
                w_state_nxt      = S_WAIT_LOCK;
                w_cnt_nxt        = '0;
                w_domain_rst_nxt = '1;
            end
            S_PLL_RST: begin
                w_domain_rst_nxt = '1;
                if (r_cnt == PLLRST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_pll_rst_nxt = 1'b1;
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt      = S_WAIT_LOCK;
                w_cnt_nxt        = '0;
                w_domain_rst_nxt = '1;
            end
        endcase
    end

    assign pll_rst_out    = r_pll_rst;
    assign domain_rst_out = r_domain_rst;
    assign all_released   = r_all_released;
    assign state_out      = r_state;

`ifdef PLL_LOCK_LOSS_COUNTER_EN
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    // Saturating count of entries into LOST
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if ((w_state_nxt == S_LOST) && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign loss_count = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Bench for pll_lock_reset_sequencer: directed scenarios plus random lock activity
// checked every cycle against a time-stamp based reference model.
module tb_pll_lock_reset_sequencer;

    localparam int unsigned LSC = 8;
    localparam int unsigned RSC = 4;
    localparam int unsigned NR  = 3;
    localparam int unsigned LTC = 32;
    localparam int unsigned PRC = 5;
    localparam int unsigned CW  = 20;
    localparam int unsigned LW  = 2;

    localparam int PH_WAIT = 0;
    localparam int PH_QUAL = 1;
    localparam int PH_LOST = 2;
    localparam int PH_PRST = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_lock_in;
    logic          pll_rst_out;
    logic [NR-1:0] domain_rst_out;
    logic          all_released;
    logic [2:0]    state_out;
`ifdef PLL_LOCK_LOSS_COUNTER_EN
    logic [LW-1:0] loss_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus the edge index at which the phase began
    int   n = 0;
    int   m_phase = PH_WAIT;
    int   m_t0 = 0;
    int   m_tq = 0;
    int   m_tp = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    int   m_loss = 0;

    always #5 clk = ~clk;

    pll_lock_reset_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .RELEASE_STEP_CYCLES(RSC),
        .NUM_RESETS         (NR),
        .LOCK_TIMEOUT_CYCLES(LTC),
        .PLL_RST_CYCLES     (PRC),
        .CNT_W              (CW)
`ifdef PLL_LOCK_LOSS_COUNTER_EN
        ,
        .LOSS_CNT_W         (LW)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock_in   (pll_lock_in),
        .pll_rst_out   (pll_rst_out),
        .domain_rst_out(domain_rst_out),
        .all_released  (all_released),
        .state_out     (state_out)
`ifdef PLL_LOCK_LOSS_COUNTER_EN
        ,
        .loss_count    (loss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic model_step();
        logic ls;
        n++;
        if (rst) begin
            m_phase = PH_WAIT;
            m_t0    = n;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_loss  = 0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_lock_in;
            case (m_phase)
                PH_WAIT: begin
                    if (ls) begin
                        m_phase = PH_QUAL;
                        m_tq    = n;
                    end else if (n - m_t0 == int'(LTC)) begin
                        m_phase = PH_PRST;
                        m_tp    = n;
                    end
                end
                PH_PRST: begin
                    if (n - m_tp == int'(PRC)) begin
                        m_phase = PH_WAIT;
                        m_t0    = n;
                    end
                end
                PH_QUAL: begin
                    if (!ls) begin
                        if (n - m_tq <= int'(LSC)) begin
                            m_phase = PH_WAIT;
                            m_t0    = n;
                        end else begin
                            m_phase = PH_LOST;
                            if (m_loss < (1 << LW) - 1) m_loss++;
                        end
                    end
                end
                default: begin
                    m_phase = PH_WAIT;
                    m_t0    = n;
                end
            endcase
        end
    endtask

    task automatic check_model();
        int            e;
        int            cleared;
        int            run_e;
        logic [NR-1:0] ones;
        logic [NR-1:0] e_dom;
        logic [2:0]    e_st;
        logic          e_pll;
        logic          e_all;
        ones  = '1;
        e_dom = ones;
        e_pll = 1'b0;
        e_all = 1'b0;
        e_st  = 3'd0;
        case (m_phase)
            PH_PRST: begin
                e_st  = 3'd5;
                e_pll = 1'b1;
            end
            PH_LOST: e_st = 3'd4;
            PH_QUAL: begin
                e = n - m_tq;
                if (e < int'(LSC)) begin
                    e_st = 3'd1;
                end else begin
                    cleared = 1 + (e - int'(LSC)) / int'(RSC);
                    if (cleared > int'(NR)) cleared = int'(NR);
                    run_e = (NR == 1) ? int'(LSC) + 1 : int'(LSC + (NR - 1) * RSC);
                    e_st  = (e >= run_e) ? 3'd3 : 3'd2;
                    e_dom = ones << cleared;
                    e_all = (e_st == 3'd3);
                end
            end
            default: e_st = 3'd0;
        endcase
        chk("model_state", 32'(state_out), 32'(e_st));
        chk("model_dom", 32'(domain_rst_out), 32'(e_dom));
        chk("model_pll", 32'(pll_rst_out), 32'(e_pll));
        chk("model_all", 32'(all_released), 32'(e_all));
`ifdef PLL_LOCK_LOSS_COUNTER_EN
        chk("model_loss", 32'(loss_count), 32'(m_loss));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic run_until(input int target);
        while (n < target) tick();
    endtask

    initial begin
        int base;
        int hold;
        rst         = 1'b1;
        pll_lock_in = 1'b0;
        tick();
        tick();
        chk("rst_dom", 32'(domain_rst_out), 32'(3'b111));
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_pll", 32'(pll_rst_out), 32'd0);
        chk("rst_all", 32'(all_released), 32'd0);

        // Clean lock, then loss from RUN at cycle 40
        rst = 1'b0;
        pll_lock_in = 1'b1;
        base = n;
        run_until(base + 10); chk("s1_b0_hold", 32'(domain_rst_out), 32'(3'b111));
        run_until(base + 11); chk("s1_b0_fall", 32'(domain_rst_out), 32'(3'b110));
        run_until(base + 14); chk("s1_b1_hold", 32'(domain_rst_out), 32'(3'b110));
        run_until(base + 15); chk("s1_b1_fall", 32'(domain_rst_out), 32'(3'b100));
        run_until(base + 18); chk("s1_b2_hold", 32'(domain_rst_out), 32'(3'b100));
        run_until(base + 19);
        chk("s1_b2_fall", 32'(domain_rst_out), 32'(3'b000));
        chk("s1_all", 32'(all_released), 32'd1);
        chk("s1_run", 32'(state_out), 32'd3);
        run_until(base + 40);
        pll_lock_in = 1'b0;
        run_until(base + 43);
        chk("s3_dom", 32'(domain_rst_out), 32'(3'b111));
        chk("s3_all", 32'(all_released), 32'd0);
        chk("s3_lost", 32'(state_out), 32'd4);
        run_until(base + 44);
        chk("s3_wait", 32'(state_out), 32'd0);

        // One-cycle glitch during STABILIZE
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pll_lock_in = 1'b1;
        base = n;
        run_until(base + 6);
        pll_lock_in = 1'b0;
        run_until(base + 7);
        pll_lock_in = 1'b1;
        run_until(base + 9);
        chk("s2_restart", 32'(state_out), 32'd0);
        chk("s2_dom", 32'(domain_rst_out), 32'(3'b111));
        base = base + 7;
        run_until(base + 10); chk("s2_b0_hold", 32'(domain_rst_out), 32'(3'b111));
        run_until(base + 11); chk("s2_b0_fall", 32'(domain_rst_out), 32'(3'b110));
        run_until(base + 19); chk("s2_run", 32'(state_out), 32'd3);

        // Reset in RELEASE after bit 0 has cleared
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        base = n;
        run_until(base + 12);
        chk("s5_mid", 32'(domain_rst_out), 32'(3'b110));
        rst = 1'b1;
        run_until(base + 13);
        chk("s5_dom", 32'(domain_rst_out), 32'(3'b111));
        chk("s5_state", 32'(state_out), 32'd0);
        rst = 1'b0;
        base = n;
        run_until(base + 10); chk("s5_b0_hold", 32'(domain_rst_out), 32'(3'b111));
        run_until(base + 11); chk("s5_b0_fall", 32'(domain_rst_out), 32'(3'b110));
        run_until(base + 19);
        chk("s5_done", 32'(domain_rst_out), 32'(3'b000));
        chk("s5_all", 32'(all_released), 32'd1);

        // No lock: periodic PLL reset pulses, then reset during a pulse
        rst = 1'b1;
        pll_lock_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        base = n;
        for (int c = 1; c <= 80; c++) begin
            logic e;
            run_until(base + c);
            e = (c >= 32) && (((c - 32) % 37) < 5);
            chk("s4_pll", 32'(pll_rst_out), 32'(e));
            chk("s4_dom", 32'(domain_rst_out), 32'(3'b111));
        end
        run_until(base + 107);
        chk("s4_pulse3", 32'(pll_rst_out), 32'd1);
        rst = 1'b1;
        run_until(base + 108);
        chk("s4_rst_drop", 32'(pll_rst_out), 32'd0);
        chk("s4_rst_state", 32'(state_out), 32'd0);

`ifdef PLL_LOCK_LOSS_COUNTER_EN
        // Repeated losses from RUN, saturating count
        tick();
        rst = 1'b0;
        pll_lock_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            base = n;
            run_until(base + 19);
            chk("s6_run", 32'(state_out), 32'd3);
            pll_lock_in = 1'b0;
            run_until(base + 22);
            chk("s6_loss", 32'(loss_count), 32'((k > 3) ? 3 : k));
            pll_lock_in = 1'b1;
        end
`endif

        // Random lock activity with occasional resets
        tick();
        rst = 1'b0;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                pll_lock_in = 1'($urandom_range(0, 1));
                hold = pll_lock_in ? int'($urandom_range(1, 50)) : int'($urandom_range(1, 45));
            end
            hold--;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
